// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
// Drives the shared 7-segment bus of the Eclipse clock. It scans NUM_DIGITS BCD
// digits one at a time, and each digit slot is followed by a blanking slot to
// stop ghosting. At each frame boundary it can hand the bus to a banner player
// that streams raw segment characters.
//
// Ports:
//   clk, rst_n   rising-edge clock; asynchronous active-low reset
//   time_bcd     packed BCD digits, digit i = time_bcd[4i+3:4i]
//   time_valid   time_bcd may be sampled (only read at frame start)
//   msg_req      banner player wants the display (level)
//   msg_seg      next banner character, raw segments {g,f,e,d,c,b,a}
//   msg_last     msg_seg is the final character of the banner
//   msg_ack      one-cycle pulse: msg_seg/msg_last captured on that edge
//   msg_gnt      banner player owns the display
//   seg_out      segments {g,f,e,d,c,b,a}, active-high
//   dig_en       digit enables, active-high (all ones while a banner char is shown)
//   frame_done   one-cycle pulse after each completed time frame
//   dbg_state    current scheduler state, for observation only
//
// Handshake: the banner player keeps msg_seg/msg_last valid while msg_req is
// high. The scheduler samples them on the edge that raises msg_ack. After that
// the player may present the next character, and it must be stable before the
// next msg_ack edge.
module seg_scan_scheduler #(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL      = 900,
    parameter int BLANK      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] time_bcd,
    input  logic                    time_valid,
    input  logic                    msg_req,
    input  logic [6:0]              msg_seg,
    input  logic                    msg_last,
    output logic                    msg_ack,
    output logic                    msg_gnt,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {TIME_ON, TIME_OFF, MSG_ON, MSG_OFF} state_t;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              char_q, char_d;
    logic                    last_q, last_d;
    logic                    start_q;   // a frame start is pending (set by reset)
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    ack_q, ack_d;
    logic                    gnt_q, gnt_d;
    logic                    fd_q, fd_d;

    logic slot_end, time_adv, msg_adv, do_start, do_msg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        char_d   = char_q;
        last_d   = last_q;
        ack_d    = 1'b0;
        gnt_d    = gnt_q;
        fd_d     = 1'b0;
        time_adv = 1'b0;
        msg_adv  = 1'b0;
        do_start = 1'b0;
        do_msg   = 1'b0;
        slot_end = (cnt_q == '0);

        if (start_q) begin
            do_start = 1'b1;
        end else begin
            case (state_q)
                TIME_ON: if (slot_end) begin
                    if (BLANK > 0) begin
                        state_d = TIME_OFF;
                        cnt_d   = BLANK_LD;
                    end else begin
                        time_adv = 1'b1;
                    end
                end
                TIME_OFF: if (slot_end) time_adv = 1'b1;
                MSG_ON: if (slot_end) begin
                    if (BLANK > 0) begin
                        state_d = MSG_OFF;
                        cnt_d   = BLANK_LD;
                    end else begin
                        msg_adv = 1'b1;
                    end
                end
                MSG_OFF: if (slot_end) msg_adv = 1'b1;
                default: do_start = 1'b1;
            endcase
        end

        // Arbitration happens only here, at the end of the last digit's slot.
        if (time_adv) begin
            if (idx_q == LAST_IDX) begin
                fd_d = 1'b1;
                if (msg_req) do_msg = 1'b1;
                else         do_start = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = TIME_ON;
                cnt_d   = DWELL_LD;
            end
        end

        // A banner only ends after a full character slot has finished.
        if (msg_adv) begin
            if (last_q || !msg_req) begin
                gnt_d    = 1'b0;
                do_start = 1'b1;
            end else begin
                do_msg = 1'b1;
            end
        end

        if (do_start) begin
            if (time_valid) shadow_d = time_bcd;
            idx_d   = '0;
            state_d = TIME_ON;
            cnt_d   = DWELL_LD;
        end

        if (do_msg) begin
            char_d  = msg_seg;
            last_d  = msg_last;
            ack_d   = 1'b1;
            gnt_d   = 1'b1;
            state_d = MSG_ON;
            cnt_d   = DWELL_LD;
        end

        // Outputs are registered copies of what the next state displays.
        seg_d = 7'b0000000;
        dig_d = '0;
        case (state_d)
            TIME_ON: begin
                seg_d = decode(shadow_d[{idx_d, 2'b00} +: 4]);
                dig_d = NUM_DIGITS'(1) << idx_d;
            end
            MSG_ON: begin
                seg_d = char_d;
                dig_d = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TIME_ON;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            char_q   <= '0;
            last_q   <= 1'b0;
            start_q  <= 1'b1;
            seg_q    <= '0;
            dig_q    <= '0;
            ack_q    <= 1'b0;
            gnt_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            char_q   <= char_d;
            last_q   <= last_d;
            start_q  <= 1'b0;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            ack_q    <= ack_d;
            gnt_q    <= gnt_d;
            fd_q     <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en     = dig_q;
    assign msg_ack    = ack_q;
    assign msg_gnt    = gnt_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with NUM_DIGITS=4, DWELL=3, BLANK=1
// (one frame = 16 cycles). Edge numbers count rising edges after reset release.
// Each value is sampled 1 time unit after its edge.
module tb_seg_scan_scheduler;

    localparam int ND = 4;

    logic          clk;
    logic          rst_n;
    logic [4*ND-1:0] time_bcd;
    logic          time_valid;
    logic          msg_req;
    logic [6:0]    msg_seg;
    logic          msg_last;
    logic          msg_ack;
    logic          msg_gnt;
    logic [6:0]    seg_out;
    logic [ND-1:0] dig_en;
    logic          frame_done;
    logic [1:0]    dbg_state;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int ack_cnt = 0;

    logic [6:0] chars [7];

    seg_scan_scheduler #(.NUM_DIGITS(ND), .DWELL(3), .BLANK(1), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_bcd   (time_bcd),
        .time_valid (time_valid),
        .msg_req    (msg_req),
        .msg_seg    (msg_seg),
        .msg_last   (msg_last),
        .msg_ack    (msg_ack),
        .msg_gnt    (msg_gnt),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [ND-1:0] dig, input logic [6:0] seg);
        chk({tag, ".dig_en"}, 32'(dig_en), 32'(dig));
        chk({tag, ".seg_out"}, 32'(seg_out), 32'(seg));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (msg_ack === 1'b1) ack_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        chars[0] = 7'b1111001; chars[1] = 7'b0111001; chars[2] = 7'b0111000;
        chars[3] = 7'b0110000; chars[4] = 7'b1110011; chars[5] = 7'b1101101;
        chars[6] = 7'b1111011;

        rst_n = 1'b0; time_bcd = 16'h1234; time_valid = 1'b1;
        msg_req = 1'b0; msg_seg = '0; msg_last = 1'b0;
        #12;
        chk_disp("reset", 4'b0000, 7'b0);
        chk("reset.ack", 32'(msg_ack), 0);
        chk("reset.gnt", 32'(msg_gnt), 0);
        chk("reset.fd", 32'(frame_done), 0);
        chk("reset.state", 32'(dbg_state), 0);
        rst_n = 1'b1;

        // First frame: digit 0 = 4, then 3, 2, 1.
        for (int e = 1; e <= 3; e++) begin
            run_to(e);
            chk_disp("f1.d0", 4'b0001, 7'b1100110);
            chk("f1.fd", 32'(frame_done), 0);
        end
        run_to(4);  chk_disp("f1.blank0", 4'b0000, 7'b0);
        run_to(5);  chk_disp("f1.d1", 4'b0010, 7'b1001111);
        time_bcd = 16'h5678;  // mid-frame change must not show until next frame
        run_to(9);  chk_disp("f1.d2", 4'b0100, 7'b1011011);
        run_to(13); chk_disp("f1.d3", 4'b1000, 7'b0000110);
        run_to(16); chk_disp("f1.blank3", 4'b0000, 7'b0);
        chk("f1.fd_end", 32'(frame_done), 0);

        run_to(17); chk("f2.fd", 32'(frame_done), 1);
        chk_disp("f2.d0", 4'b0001, 7'b1111111);
        run_to(18); chk("f2.fd_drop", 32'(frame_done), 0);
        run_to(21); chk_disp("f2.d1", 4'b0010, 7'b0000111);
        time_bcd = 16'h999A; time_valid = 1'b0;

        run_to(33); chk("f3.fd", 32'(frame_done), 1);
        chk_disp("f3.hold_d0", 4'b0001, 7'b1111111);
        time_valid = 1'b1;

        // Frame 4: digit 0 = A is blank while its enable still comes on.
        for (int e = 49; e <= 51; e++) begin
            run_to(e);
            chk_disp("f4.dA", 4'b0001, 7'b0);
        end
        run_to(52); chk_disp("f4.blank0", 4'b0000, 7'b0);
        run_to(53); chk_disp("f4.d1", 4'b0010, 7'b1101111);

        // Banner raised mid-frame; grant only at edge 65.
        run_to(55);
        msg_req = 1'b1; msg_seg = chars[0]; msg_last = 1'b0;
        time_bcd = 16'h4321;
        ack_cnt = 0;
        run_to(64);
        chk("m1.no_gnt_mid", 32'(msg_gnt), 0);
        chk("m1.no_ack_mid", 32'(ack_cnt), 0);
        for (int k = 0; k < 7; k++) begin
            run_to(65 + 4 * k);
            chk("m1.ack", 32'(msg_ack), 1);
            chk("m1.gnt", 32'(msg_gnt), 1);
            chk_disp("m1.char", 4'b1111, chars[k]);
            if (k == 0) chk("m1.fd_at_grant", 32'(frame_done), 1);
            if (k < 6) begin
                msg_seg  = chars[k + 1];
                msg_last = (k + 1 == 6);
            end
            run_to(67 + 4 * k);
            chk("m1.ack_drop", 32'(msg_ack), 0);
            chk_disp("m1.hold", 4'b1111, chars[k]);
            run_to(68 + 4 * k);
            chk_disp("m1.blank", 4'b0000, 7'b0);
            chk("m1.gnt_blank", 32'(msg_gnt), 1);
        end
        run_to(93);
        chk("m1.gnt_end", 32'(msg_gnt), 0);
        chk("m1.ack_end", 32'(msg_ack), 0);
        chk("m1.no_fd", 32'(frame_done), 0);
        chk("m1.acks", 32'(ack_cnt), 7);
        chk_disp("m1.time_d0", 4'b0001, 7'b0000110);
        msg_req = 1'b0; msg_last = 1'b0;
        run_to(97); chk_disp("m1.time_d1", 4'b0010, 7'b1011011);

        // Banner with no last flag, request dropped during second character.
        run_to(100);
        msg_req = 1'b1; msg_seg = chars[0];
        ack_cnt = 0;
        run_to(109);
        chk("m2.fd", 32'(frame_done), 1);
        chk("m2.ack1", 32'(msg_ack), 1);
        chk_disp("m2.char1", 4'b1111, chars[0]);
        msg_seg = chars[1];
        run_to(113);
        chk("m2.ack2", 32'(msg_ack), 1);
        chk_disp("m2.char2", 4'b1111, chars[1]);
        run_to(114);
        msg_req = 1'b0;
        run_to(115); chk_disp("m2.char2_hold", 4'b1111, chars[1]);
        run_to(116); chk_disp("m2.blank2", 4'b0000, 7'b0);
        chk("m2.gnt_blank", 32'(msg_gnt), 1);
        run_to(117);
        chk("m2.gnt_end", 32'(msg_gnt), 0);
        chk_disp("m2.time_d0", 4'b0001, 7'b0000110);
        run_to(130);
        chk("m2.acks", 32'(ack_cnt), 2);

        // Asynchronous reset in the middle of a banner character.
        msg_req = 1'b1; msg_seg = chars[2];
        run_to(133);
        chk("r.gnt", 32'(msg_gnt), 1);
        chk_disp("r.char", 4'b1111, chars[2]);
        run_to(134);
        #2 rst_n = 1'b0;
        #1;
        chk_disp("r.async", 4'b0000, 7'b0);
        chk("r.async_gnt", 32'(msg_gnt), 0);
        chk("r.async_state", 32'(dbg_state), 0);
        msg_req = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk_disp("r.restart_d0", 4'b0001, 7'b0000110);
        chk("r.restart_gnt", 32'(msg_gnt), 0);
        chk("r.restart_ack", 32'(msg_ack), 0);
        step(); step(); step();
        chk_disp("r.restart_blank", 4'b0000, 7'b0);
        step();
        chk_disp("r.restart_d1", 4'b0010, 7'b1011011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
